// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MDU_TIMEOUT = 64;
    localparam int         DEF_CNT_W       = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int CNT_W = hazard_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for load-use hazards, taken branches and multi-cycle MDU ops.
// Define HAZARD_PERF_CNT_EN to implement the stall_cnt performance counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = DEF_MDU_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             mdu_start_e,
    input  logic             mdu_done,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WDT_W = $clog2(MDU_TIMEOUT + 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [WDT_W-1:0] wdt_q;
    logic             err_q;

    logic load_use;
    logic mdu_block;
    logic timeout;

    assign load_use  = load_e && (rd_e != REG_ZERO) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mdu_block = mdu_start_e && !mdu_done;
    assign timeout   = (state_q == MDU_WAIT) && !mdu_done &&
                       (wdt_q == WDT_W'(MDU_TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN: begin
                if (!pc_src_e && mdu_block) begin
                    state_nxt = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                if (mdu_done || timeout) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Watchdog loads 1 on entry so it equals k in the k-th cycle after the MDU op entered EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q <= '0;
        end else if (state_q == RUN) begin
            wdt_q <= (!pc_src_e && mdu_block) ? WDT_W'(1) : '0;
        end else if (!mdu_done && !timeout) begin
            wdt_q <= wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    // Outputs are forced low while rst is held so the pipeline sees no stale stall.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        mdu_err = 1'b0;
        if (!rst) begin
            mdu_err = err_q || timeout;
            case (state_q)
                RUN: begin
                    if (pc_src_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (mdu_block) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (!mdu_done && !timeout) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_d),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch flush, MDU wait, watchdog and reset.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rd_e;
    logic             load_e, pc_src_e, mdu_start_e, mdu_done;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_err;
    logic [CNT_W-1:0] stall_cnt;

    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    hazard_ctrl #(
        .MDU_TIMEOUT (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_e        (rd_e),
        .load_e      (load_e),
        .pc_src_e    (pc_src_e),
        .mdu_start_e (mdu_start_e),
        .mdu_done    (mdu_done),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_m     (flush_m),
        .mdu_err     (mdu_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs, check outputs {sf,sd,se,fd,fe,fm,err} and stall_cnt.
    task automatic vec(input string tag, input logic r,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic ld, input logic pc, input logic st, input logic dn,
                       input logic [6:0] exp);
        logic [CNT_W-1:0] exp_cnt;
        rst = r; rs1_d = s1; rs2_d = s2; rd_e = d;
        load_e = ld; pc_src_e = pc; mdu_start_e = st; mdu_done = dn;
        @(negedge clk);
        check({tag, "/out"},
              {25'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_err},
              {25'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
        exp_cnt = cnt_model;
`else
        exp_cnt = '0;
`endif
        check({tag, "/cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        if (r) cnt_model = '0;
        else if (exp[5] && cnt_model != '1) cnt_model = cnt_model + 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rs1_d = '0; rs2_d = '0; rd_e = '0;
        load_e = 0; pc_src_e = 0; mdu_start_e = 0; mdu_done = 0;
        @(posedge clk);
        #1;
        //                   rst rs1 rs2 rd  ld pc st dn   sf sd se fd fe fm err
        vec("reset",          1, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        vec("idle",           0, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        vec("lu_rs1",         0, 5,  0,  5,  1, 0, 0, 0, 7'b1100100);
        vec("lu_redecode",    0, 5,  0,  9,  0, 0, 0, 0, 7'b0000000);
        vec("lu_rs2",         0, 1,  7,  7,  1, 0, 0, 0, 7'b1100100);
        vec("lu_rd0",         0, 0,  0,  0,  1, 0, 0, 0, 7'b0000000);
        vec("lu_nomatch",     0, 6,  7,  5,  1, 0, 0, 0, 7'b0000000);
        vec("lu_notload",     0, 5,  0,  5,  0, 0, 0, 0, 7'b0000000);
        vec("branch_over_lu", 0, 5,  0,  5,  1, 1, 0, 0, 7'b0001100);
        // MDU op in cycle 10, done in cycle 15: five stall cycles.
        vec("mdu_c10",        0, 0,  0,  3,  0, 0, 1, 0, 7'b1110010);
        vec("mdu_c11",        0, 0,  0,  3,  0, 0, 1, 0, 7'b1110010);
        vec("mdu_c12_ignpc",  0, 0,  0,  3,  0, 1, 1, 0, 7'b1110010);
        vec("mdu_c13_ignlu",  0, 3,  0,  3,  1, 0, 1, 0, 7'b1110010);
        vec("mdu_c14",        0, 0,  0,  3,  0, 0, 1, 0, 7'b1110010);
        vec("mdu_c15_done",   0, 0,  0,  3,  0, 0, 1, 1, 7'b0000000);
        vec("mdu_back_run",   0, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        vec("mdu_zero_wait",  0, 0,  0,  0,  0, 0, 1, 1, 7'b0000000);
        vec("zw_still_run",   0, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        // Watchdog: start in N, stalls N..N+7, abort in N+8.
        vec("wdt_n",          0, 0,  0,  0,  0, 0, 1, 0, 7'b1110010);
        for (int i = 1; i < 8; i++) begin
            vec($sformatf("wdt_n%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 7'b1110010);
        end
        vec("wdt_abort",      0, 0,  0,  0,  0, 0, 0, 0, 7'b0000001);
        vec("err_sticky",     0, 0,  0,  0,  0, 0, 0, 0, 7'b0000001);
        vec("late_done",      0, 0,  0,  0,  0, 0, 0, 1, 7'b0000001);
        vec("lu_after_err",   0, 4,  0,  4,  1, 0, 0, 0, 7'b1100101);
        // Reset in the middle of an MDU wait; the late done must be ignored.
        vec("rw_start",       0, 0,  0,  0,  0, 0, 1, 0, 7'b1110011);
        vec("rw_wait",        0, 0,  0,  0,  0, 0, 0, 0, 7'b1110011);
        vec("rw_rst",         1, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        vec("rw_late_done",   0, 0,  0,  0,  0, 0, 0, 1, 7'b0000000);
        vec("rw_idle",        0, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        vec("rw_lu",          0, 0,  2,  2,  1, 0, 0, 0, 7'b1100100);
        vec("rw_final",       0, 0,  0,  0,  0, 0, 0, 0, 7'b0000000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush sequencer for the five-stage core. It sits beside the decode stage and freezes the fetch, decode and execute registers on load-use hazards and multi-cycle MDU operations. The frozen decode instruction is the one feeding the immediate extender and register file, so both stay stable while the stall lasts. It also squashes wrong-path instructions after a taken branch or jump and guards MDU waits with a watchdog.

## Interface
- MDU_TIMEOUT, 64: maximum cycles spent in MDU_WAIT before abort.
- CNT_W, 32: width of the stall performance counter.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_d  in  5  decode-stage source register 1.
- rs2_d  in  5  decode-stage source register 2.
- rd_e  in  5  execute-stage destination register.
- load_e  in  1  execute-stage instruction is a load (ResultSrcE[0]).
- pc_src_e  in  1  execute-stage branch/jump taken.
- mdu_start_e  in  1  execute-stage instruction is a multi-cycle MDU op.
- mdu_done  in  1  MDU result valid this cycle (single-cycle pulse).
- stall_f  out  1  hold PC / IF-ID enable low.
- stall_d  out  1  hold IF/ID register.
- stall_e  out  1  hold ID/EX register.
- flush_d  out  1  clear IF/ID to NOP.
- flush_e  out  1  clear ID/EX to NOP.
- flush_m  out  1  clear EX/MEM to NOP (bubble behind a waiting MDU op).
- mdu_err  out  1  sticky: watchdog expired.
- stall_cnt  out  CNT_W  cycles with stall_d high.

## Operation
- Outputs are combinational from registered state plus current inputs. State is updated on clk only.
- States: RUN, MDU_WAIT. Reset state is RUN.
- RUN:
  - Load-use hazard: load_e & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d). Response: stall_f=stall_d=1, flush_e=1 for that cycle only.
  - pc_src_e=1: flush_d=flush_e=1. Takes priority over a load-use stall; stalls are suppressed that cycle.
  - mdu_start_e=1 & mdu_done=0: stall_f=stall_d=stall_e=1, flush_m=1. Next state MDU_WAIT; watchdog counter loads 1.
  - mdu_start_e=1 & mdu_done=1: zero-wait op. No stall; stay in RUN.
- MDU_WAIT:
  - While mdu_done=0: stall_f=stall_d=stall_e=1, flush_m=1, watchdog counter increments.
  - mdu_done=1: all stalls and flushes deassert in that same cycle; next state RUN.
  - Watchdog counter reaching MDU_TIMEOUT with mdu_done=0: set mdu_err, release stalls that cycle, next state RUN.
  - pc_src_e, load_e and mdu_start_e are ignored in this state.
- Register index 0 never causes a hazard.
- mdu_err is cleared only by rst.
- Reset values: every output 0; stall_cnt 0; mdu_err 0.
- rst asserted mid-MDU_WAIT: state returns to RUN on that edge. All outputs read 0 from the following cycle. A late mdu_done is ignored.

## Timing
- Load-use: 1 stall cycle. The dependent instruction re-decodes in cycle N+1.
- MDU op entering EX in cycle N with mdu_done in cycle M>N: stalls are high for cycles N..M-1 and low in cycle M. Total stall length is M-N cycles.
- Watchdog abort happens in cycle N+MDU_TIMEOUT.
- Branch flush: 1 cycle, no stall.
- stall_cnt increments on the edge following every cycle with stall_d=1. It saturates at all-ones and does not wrap.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt counter is implemented as above.
- Not defined: the counter logic is omitted and stall_cnt is tied to 0. The port is still present.

## Structure
- Package hazard_pkg holds:
  - the state enum (RUN, MDU_WAIT);
  - REG_ZERO = 5'd0;
  - default constants for MDU_TIMEOUT and CNT_W.
- One sub-module, hazard_perf_cnt: a saturating CNT_W counter with enable, instantiated only under HAZARD_PERF_CNT_EN.

## Test plan
- Load x5 in EX (rd_e=5, load_e=1), rs1_d=5 → stall_f=stall_d=flush_e=1 for exactly one cycle. With rd_e=0 instead → no stall.
- pc_src_e=1 while the load-use condition is also true → flush_d=flush_e=1, stall_f=stall_d=0.
- mdu_start_e in cycle 10, mdu_done in cycle 15 → stall_e and flush_m high in cycles 10–14, low in cycle 15, state back to RUN. stall_cnt=5 with the macro defined.
- mdu_start_e and mdu_done in the same cycle → no stall asserted, state stays RUN.
- MDU_TIMEOUT=8, mdu_done never arrives → stalls drop in cycle N+8, mdu_err=1 and stays 1 until rst.
- rst pulsed during MDU_WAIT, then mdu_done → all outputs 0, state RUN, stall_cnt=0.
